// File: rtl/cpu_trace_buffer_pkg.sv
// Shared widths, FSM state encoding and trigger-mode encoding for the CPU trace buffer.
package cpu_trace_buffer_pkg;
  localparam int PC_W     = 8;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int SAMPLE_W = PC_W + 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TRIG_IMM   = 2'd0,
    TRIG_PC    = 2'd1,
    TRIG_EXT   = 2'd2,
    TRIG_NEVER = 2'd3
  } trig_mode_t;
endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Simple dual-port trace storage: synchronous write, one-cycle registered read.
module cpu_trace_buffer_ram #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 72
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Sample storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, cleared by reset so rd_data starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= {WIDTH{1'b0}};
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/cpu_trace_buffer.sv
// Execution trace capture: circular sample buffer with programmable trigger,
// post-trigger count and oldest-first readout.
import cpu_trace_buffer_pkg::*;

module cpu_trace_buffer #(
  parameter int PC_W   = cpu_trace_buffer_pkg::PC_W,
  parameter int DATA_W = cpu_trace_buffer_pkg::DATA_W,
  parameter int DEPTH  = cpu_trace_buffer_pkg::DEPTH,
  parameter int ADDR_W = cpu_trace_buffer_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic [1:0]               trig_mode,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic                     trig_in,
  input  logic [ADDR_W-1:0]        post_cnt,
  input  logic                     cap_valid,
  input  logic [PC_W-1:0]          pc,
  input  logic [DATA_W-1:0]        insc,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     rd_en,
  output logic [PC_W+2*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic [1:0]               state,
  output logic [ADDR_W:0]          count,
  output logic                     wrapped
);
  localparam int SW = PC_W + 2 * DATA_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);

  state_t             cur_st;
  state_t             nxt_st;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  remaining;
  logic [ADDR_W:0]    rd_idx;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wr_en;
  logic               trig_hit;
  logic               rd_issue;

  assign state   = cur_st;
  assign wr_en   = cap_valid && !arm && (cur_st == ST_ARMED || cur_st == ST_POST);
  assign rd_issue = rd_en && !arm && (cur_st == ST_DONE) && (rd_idx < count);
  // Reads walk forward from the oldest surviving entry; wr_ptr is frozen in DONE.
  assign rd_addr = (wrapped ? wr_ptr : {ADDR_W{1'b0}}) + rd_idx[ADDR_W-1:0];

  // Trigger compare against the sample currently being written.
  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode)
      TRIG_IMM:   trig_hit = 1'b1;
      TRIG_PC:    trig_hit = (pc == trig_pc);
      TRIG_EXT:   trig_hit = trig_in;
      TRIG_NEVER: trig_hit = 1'b0;
      default:    trig_hit = 1'b0;
    endcase
  end

  // Next-state logic; arm restarts capture from any state.
  always_comb begin
    nxt_st = cur_st;
    if (arm) begin
      nxt_st = ST_ARMED;
    end else begin
      case (cur_st)
        ST_ARMED: begin
          if (wr_en && trig_hit) begin
            nxt_st = (post_cnt == {ADDR_W{1'b0}}) ? ST_DONE : ST_POST;
          end else begin
            nxt_st = ST_ARMED;
          end
        end
        ST_POST: begin
          if (wr_en && remaining == ADDR_W'(1)) begin
            nxt_st = ST_DONE;
          end else begin
            nxt_st = ST_POST;
          end
        end
        default: nxt_st = cur_st;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_st <= ST_IDLE;
    end else begin
      cur_st <= nxt_st;
    end
  end

  // Write pointer, occupancy, post-trigger countdown and readout tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= {ADDR_W{1'b0}};
      count     <= {(ADDR_W + 1){1'b0}};
      wrapped   <= 1'b0;
      remaining <= {ADDR_W{1'b0}};
      rd_idx    <= {(ADDR_W + 1){1'b0}};
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else if (arm) begin
      wr_ptr    <= {ADDR_W{1'b0}};
      count     <= {(ADDR_W + 1){1'b0}};
      wrapped   <= 1'b0;
      remaining <= {ADDR_W{1'b0}};
      rd_idx    <= {(ADDR_W + 1){1'b0}};
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      rd_valid <= rd_issue;
      rd_last  <= rd_issue && ((rd_idx + (ADDR_W + 1)'(1)) == count);
      if (rd_issue) begin
        rd_idx <= rd_idx + (ADDR_W + 1)'(1);
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (count == CNT_FULL) begin
          wrapped <= 1'b1;
        end else begin
          count <= count + (ADDR_W + 1)'(1);
        end
        // Only the latch taken on the trigger sample survives into POST.
        if (cur_st == ST_ARMED) begin
          remaining <= post_cnt;
        end else begin
          remaining <= remaining - ADDR_W'(1);
        end
      end
    end
  end

  cpu_trace_buffer_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WIDTH  (SW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({pc, insc, alu_out}),
    .re      (rd_issue),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed + randomized bench for cpu_trace_buffer against a queue-based capture model.
module tb_cpu_trace_buffer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic [1:0]  trig_mode;
  logic [7:0]  trig_pc;
  logic        trig_in;
  logic [3:0]  post_cnt;
  logic        cap_valid;
  logic [7:0]  pc;
  logic [31:0] insc;
  logic [31:0] alu_out;
  logic        rd_en;
  logic [71:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic [1:0]  state;
  logic [4:0]  count;
  logic        wrapped;

  int npass = 0;
  int ntotal = 0;

  // Model: the stored samples (newest last, at most 16 kept), total stored, phase.
  logic [71:0] mq[$];
  int mtotal = 0;
  int mstate = 0;
  int mremain = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
    .trig_in(trig_in), .post_cnt(post_cnt), .cap_valid(cap_valid), .pc(pc), .insc(insc),
    .alu_out(alu_out), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .state(state), .count(count), .wrapped(wrapped)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    mtotal = 0;
    mstate = 0;
    mremain = 0;
  endtask

  task automatic model_store(input logic [71:0] s, input logic ti);
    if (mstate == 1 || mstate == 2) begin
      mq.push_back(s);
      if (mq.size() > 16) void'(mq.pop_front());
      mtotal++;
      if (mstate == 1) begin
        if (trig_mode == 2'd0 || (trig_mode == 2'd1 && s[71:64] == trig_pc) ||
            (trig_mode == 2'd2 && ti)) begin
          mremain = int'(post_cnt);
          mstate = (post_cnt == 4'd0) ? 3 : 2;
        end
      end else begin
        mremain--;
        if (mremain == 0) mstate = 3;
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_state"}, 72'(state), 72'(mstate));
    check({tag, "_count"}, 72'(count), 72'((mtotal > 16) ? 16 : mtotal));
    check({tag, "_wrapped"}, 72'(wrapped), 72'(mtotal > 16));
  endtask

  // All tasks start and end on a falling edge.
  task automatic arm_cfg(input logic [1:0] m, input logic [7:0] tpc, input logic [3:0] pcnt,
                         input logic also_rd);
    trig_mode = m;
    trig_pc = tpc;
    post_cnt = pcnt;
    arm = 1'b1;
    rd_en = also_rd;
    @(negedge clk);
    arm = 1'b0;
    rd_en = 1'b0;
    model_reset();
    mstate = 1;
  endtask

  task automatic sample(input logic [7:0] p, input logic ti);
    logic [71:0] s;
    s = {p, 32'($urandom()), 32'($urandom())};
    pc = s[71:64];
    insc = s[63:32];
    alu_out = s[31:0];
    trig_in = ti;
    cap_valid = 1'b1;
    @(negedge clk);
    cap_valid = 1'b0;
    trig_in = 1'b0;
    model_store(s, ti);
  endtask

  task automatic read_all(input string tag);
    int n;
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      check($sformatf("%s_valid%0d", tag, i), 72'(rd_valid), 72'(1));
      check($sformatf("%s_data%0d", tag, i), rd_data, mq[i]);
      check($sformatf("%s_last%0d", tag, i), 72'(rd_last), 72'(i == n - 1));
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check({tag, "_extra_rd_valid"}, 72'(rd_valid), 72'(0));
    @(negedge clk);
    check({tag, "_valid_idle"}, 72'(rd_valid), 72'(0));
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; trig_mode = 2'd0; trig_pc = 8'd0; trig_in = 1'b0;
    post_cnt = 4'd0; cap_valid = 1'b0; pc = 8'd0; insc = 32'd0; alu_out = 32'd0; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_data", rd_data, 72'(0));
    check("rst_rd_last", 72'(rd_last), 72'(0));
    check_status("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: reset in the middle of capture traffic
    arm_cfg(2'd3, 8'd0, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) sample(8'(i * 4), 1'b0);
    check_status("t1_pre");
    cap_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_status("t1_rst");
    check("t1_rd_valid", 72'(rd_valid), 72'(0));
    @(negedge clk);
    cap_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // 2: immediate trigger, post_cnt=3
    arm_cfg(2'd0, 8'd0, 4'd3, 1'b0);
    for (int i = 0; i < 10; i++) sample(8'(i), 1'b0);
    check_status("t2");
    read_all("t2");

    // 3: pc match 0x20, post_cnt=2
    arm_cfg(2'd1, 8'h20, 4'd2, 1'b0);
    for (int i = 0; i < 14; i++) sample(8'(i * 4), 1'b0);
    check_status("t3");
    read_all("t3");

    // 4: pc match 0x50, post_cnt=5, buffer wraps
    arm_cfg(2'd1, 8'h50, 4'd5, 1'b0);
    for (int i = 0; i < 30; i++) sample(8'(i * 4), 1'b0);
    check_status("t4");
    check("t4_oldest_pc", 72'(mq[0][71:64]), 72'(8'h28));
    read_all("t4");

    // 6a: arm together with rd_en while DONE
    arm_cfg(2'd0, 8'd0, 4'd0, 1'b1);
    check_status("t6_arm_rd");
    check("t6_arm_rd_valid", 72'(rd_valid), 72'(0));

    // 5: external trigger on sample 3, reset after two post samples, then fresh capture
    arm_cfg(2'd2, 8'd0, 4'd7, 1'b0);
    for (int i = 0; i < 6; i++) sample(8'(i * 4), i == 3);
    check_status("t5_post");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_status("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    arm_cfg(2'd2, 8'd0, 4'd7, 1'b0);
    for (int i = 0; i < 15; i++) sample(8'(8'h80 + i * 4), i == 5);
    check_status("t5_fresh");
    read_all("t5");

    // Mode 3 never triggers and keeps wrapping
    arm_cfg(2'd3, 8'd0, 4'd0, 1'b0);
    for (int i = 0; i < 20; i++) sample(8'($urandom_range(255, 0)), 1'b1);
    check_status("never");

    // Randomized pc-match captures
    for (int r = 0; r < 4; r++) begin
      int k;
      k = int'($urandom_range(29, 0));
      arm_cfg(2'd1, 8'(k * 4), 4'($urandom_range(15, 0)), 1'b0);
      for (int i = 0; i < 50; i++) sample(8'(i * 4), 1'($urandom_range(1, 0)));
      check_status($sformatf("rnd%0d", r));
      read_all($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
